// File: rtl/rcn_av_pkg.sv
// Shared widths, arbiter state encoding and debug view for the rcn Avalon arbiter.
package rcn_av_pkg;

    localparam int RCN_AV_ADDR_W = 22;
    localparam int RCN_AV_DATA_W = 32;
    localparam int RCN_AV_BE_W   = 4;

    typedef enum logic {
        ARB_UNLOCKED = 1'b0,
        ARB_LOCKED   = 1'b1
    } arb_state_t;

    // Fixed-width observation of internal state; narrower fields are zero-extended.
    typedef struct packed {
        arb_state_t  state;
        logic [1:0]  lock_port;
        logic [1:0]  rr_ptr;
        logic [15:0] rd_count;
    } rcn_av_dbg_t;

    function automatic int rcn_av_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rcn_av_owner_fifo.sv
// In-order FIFO of port indices, one entry per read still awaiting its data.
module rcn_av_owner_fifo
    import rcn_av_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = 1
) (
    input  logic                     av_clk,
    input  logic                     av_rst,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge av_clk or posedge av_rst) begin
        if (av_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: head is only consumed while the FIFO is non-empty.
    always_ff @(posedge av_clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/rcn_av_arb.sv
// N-port Avalon-MM arbiter in front of one avalon2rcn master, routing read data back by issue order.
// Define RCN_AV_ARB_FIXED_PRIO_EN for fixed lowest-index-first priority instead of round-robin.
module rcn_av_arb
    import rcn_av_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int RD_DEPTH  = 8
) (
    input  logic                               av_clk,
    input  logic                               av_rst,
    input  logic [RCN_AV_ADDR_W*NUM_PORTS-1:0] s_address,
    input  logic [NUM_PORTS-1:0]               s_write,
    input  logic [NUM_PORTS-1:0]               s_read,
    input  logic [RCN_AV_BE_W*NUM_PORTS-1:0]   s_byteenable,
    input  logic [RCN_AV_DATA_W*NUM_PORTS-1:0] s_writedata,
    output logic [NUM_PORTS-1:0]               s_waitrequest,
    output logic [RCN_AV_DATA_W-1:0]           s_readdata,
    output logic [NUM_PORTS-1:0]               s_readdatavalid,
    output logic [RCN_AV_ADDR_W-1:0]           m_address,
    output logic                               m_write,
    output logic                               m_read,
    output logic [RCN_AV_BE_W-1:0]             m_byteenable,
    output logic [RCN_AV_DATA_W-1:0]           m_writedata,
    input  logic                               m_waitrequest,
    input  logic [RCN_AV_DATA_W-1:0]           m_readdata,
    input  logic                               m_readdatavalid,
    output rcn_av_dbg_t                        dbg
);

    localparam int IDX_W = rcn_av_idx_w(NUM_PORTS);
    localparam int CNT_W = $clog2(RD_DEPTH) + 1;

    // Handshake: a request (read|write) is held until the cycle it is seen with
    // waitrequest low; that cycle is the transfer. Read data returns later, in issue order.

    arb_state_t       state, state_nxt;
    logic [IDX_W-1:0] lock_port, lock_port_nxt;
    logic [IDX_W-1:0] grant;
    logic             grant_vld;
    logic [IDX_W-1:0] search_base;
    logic [NUM_PORTS-1:0] req, eligible;
    logic             accept;
    logic             fifo_full, fifo_empty;
    logic [IDX_W-1:0] fifo_head;
    logic [CNT_W-1:0] fifo_count;

    function automatic logic [IDX_W-1:0] port_add(input logic [IDX_W-1:0] base, input int off);
        logic [IDX_W:0] s;
        s = {1'b0, base} + (IDX_W+1)'(off);
        if (s >= (IDX_W+1)'(NUM_PORTS)) s = s - (IDX_W+1)'(NUM_PORTS);
        return s[IDX_W-1:0];
    endfunction

    assign req      = s_read | s_write;
    assign eligible = req & ~(s_read & {NUM_PORTS{fifo_full}});
    assign accept   = (m_read | m_write) & ~m_waitrequest;

`ifdef RCN_AV_ARB_FIXED_PRIO_EN
    assign search_base = '0;
`else
    always_ff @(posedge av_clk or posedge av_rst) begin
        if (av_rst)      search_base <= '0;
        else if (accept) search_base <= port_add(grant, 1);
    end
`endif

    always_comb begin
        grant     = lock_port;
        grant_vld = 1'b0;
        if (state == ARB_LOCKED) begin
            grant_vld = 1'b1;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (!grant_vld && eligible[port_add(search_base, i)]) begin
                    grant     = port_add(search_base, i);
                    grant_vld = 1'b1;
                end
            end
        end
    end

    always_comb begin
        m_address     = s_address[int'(grant)*RCN_AV_ADDR_W +: RCN_AV_ADDR_W];
        m_byteenable  = s_byteenable[int'(grant)*RCN_AV_BE_W +: RCN_AV_BE_W];
        m_writedata   = s_writedata[int'(grant)*RCN_AV_DATA_W +: RCN_AV_DATA_W];
        m_read        = grant_vld & ~av_rst & s_read[grant];
        m_write       = grant_vld & ~av_rst & s_write[grant];
        s_waitrequest = '1;
        if (grant_vld && !av_rst) s_waitrequest[grant] = m_waitrequest;
    end

    // A stalled request pins the grant until it completes or is (illegally) withdrawn.
    always_comb begin
        state_nxt     = state;
        lock_port_nxt = lock_port;
        if (accept) begin
            state_nxt = ARB_UNLOCKED;
        end else if (state == ARB_LOCKED) begin
            if (!req[lock_port]) state_nxt = ARB_UNLOCKED;
        end else if ((m_read || m_write) && m_waitrequest) begin
            state_nxt     = ARB_LOCKED;
            lock_port_nxt = grant;
        end
    end

    always_ff @(posedge av_clk or posedge av_rst) begin
        if (av_rst) begin
            state     <= ARB_UNLOCKED;
            lock_port <= '0;
        end else begin
            state     <= state_nxt;
            lock_port <= lock_port_nxt;
        end
    end

    rcn_av_owner_fifo #(
        .DEPTH (RD_DEPTH),
        .W     (IDX_W)
    ) u_owner_fifo (
        .av_clk (av_clk),
        .av_rst (av_rst),
        .push   (accept & m_read),
        .din    (grant),
        .pop    (m_readdatavalid),
        .head   (fifo_head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    assign s_readdata = m_readdata;

    always_comb begin
        s_readdatavalid = '0;
        if (m_readdatavalid && !fifo_empty && !av_rst) s_readdatavalid[fifo_head] = 1'b1;
    end

    always_comb begin
        dbg.state     = state;
        dbg.lock_port = 2'(lock_port);
        dbg.rr_ptr    = 2'(search_base);
        dbg.rd_count  = 16'(fifo_count);
    end

endmodule
